// File: rtl/vn_iter_update_ctrl.sv
// VN IB-RAM iteration update controller.
// One request runs FETCH (ROM latch strobe), PRIME (ROM read latency),
// WRITE (one page per cycle) and DONE (completion pulse). Then it advances
// the iteration counter that selects the ROM group and the in-group index.
// Every output is a flop, loaded from the next-state values, so each output
// lines up with the state the FSM is in during that cycle.
module vn_iter_update_ctrl #(
    parameter int ITER_ADDR_BW = 5,
    parameter int PAGE_ADDR_BW = 6,
    parameter int PAGE_NUM     = 64,
    parameter int ITER_GRP     = 25,
    parameter int ITER_MAX     = 50,
    parameter int ROM_LAT      = 2
) (
    input  logic                    write_clk,
    input  logic                    rst,
    input  logic                    update_req,
    input  logic                    iter_clr,
    output logic                    busy,
    output logic                    update_done,
    output logic                    rom_port_fetch,
    output logic [ITER_ADDR_BW-1:0] latch_iter,
    output logic                    iter_switch,
    output logic                    wr_en,
    output logic [PAGE_ADDR_BW-1:0] wr_page_addr,
    output logic                    last_iter
);

    localparam int ITER_CNT_BW = (ITER_MAX > 1) ? $clog2(ITER_MAX) : 1;
    localparam int PRIME_BW    = (ROM_LAT  > 1) ? $clog2(ROM_LAT)  : 1;

    localparam logic [ITER_CNT_BW-1:0]  ITER_LAST  = ITER_CNT_BW'(ITER_MAX - 1);
    localparam logic [ITER_CNT_BW-1:0]  ITER_GRP_C = ITER_CNT_BW'(ITER_GRP);
    localparam logic [PRIME_BW-1:0]     PRIME_LAST = PRIME_BW'(ROM_LAT - 1);
    localparam logic [PAGE_ADDR_BW-1:0] PAGE_LAST  = PAGE_ADDR_BW'(PAGE_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRIME,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ITER_CNT_BW-1:0]  iter_cnt_q, iter_cnt_d;
    logic [PRIME_BW-1:0]     prime_cnt_q, prime_cnt_d;

    logic                    busy_q, busy_d;
    logic                    update_done_q, update_done_d;
    logic                    rom_port_fetch_q, rom_port_fetch_d;
    logic                    wr_en_q, wr_en_d;
    logic [PAGE_ADDR_BW-1:0] wr_page_addr_q, wr_page_addr_d;
    logic [ITER_ADDR_BW-1:0] latch_iter_q, latch_iter_d;
    logic                    iter_switch_q, iter_switch_d;
    logic                    last_iter_q, last_iter_d;

    // Next-state logic: FSM sequencing, PRIME latency count, iteration counter.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        iter_cnt_d  = iter_cnt_q;
        prime_cnt_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                // A clear applies before any update, so an update requested in the same cycle uses iteration 0.
                if (iter_clr) begin
                    iter_cnt_d = '0;
                end
                if (update_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    prime_cnt_d = prime_cnt_q + PRIME_BW'(1);
                end
            end
            ST_WRITE: begin
                // wr_page_addr_q holds the page being written this cycle.
                if (wr_page_addr_q == PAGE_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                iter_cnt_d = (iter_cnt_q == ITER_LAST) ? '0 : iter_cnt_q + ITER_CNT_BW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, decoded from the next state and next iteration count.
    always_comb begin
        busy_d           = (state_d != ST_IDLE);
        rom_port_fetch_d = (state_d != ST_FETCH);
        wr_en_d          = (state_d == ST_WRITE);
        update_done_d    = (state_d == ST_DONE);
        wr_page_addr_d   = '0;
        if (state_d == ST_WRITE && state_q == ST_WRITE) begin
            wr_page_addr_d = wr_page_addr_q + PAGE_ADDR_BW'(1);
        end
        // The count never reaches 2*ITER_GRP, so a single subtraction gives the value mod ITER_GRP.
        if (iter_cnt_d >= ITER_GRP_C) begin
            latch_iter_d  = ITER_ADDR_BW'(iter_cnt_d - ITER_GRP_C);
            iter_switch_d = 1'b1;
        end else begin
            latch_iter_d  = ITER_ADDR_BW'(iter_cnt_d);
            iter_switch_d = 1'b0;
        end
        last_iter_d = (iter_cnt_d == ITER_LAST);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge write_clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q          <= ST_IDLE;
            iter_cnt_q       <= '0;
            prime_cnt_q      <= '0;
            busy_q           <= 1'b0;
            update_done_q    <= 1'b0;
            rom_port_fetch_q <= 1'b1;
            wr_en_q          <= 1'b0;
            wr_page_addr_q   <= '0;
            latch_iter_q     <= '0;
            iter_switch_q    <= 1'b0;
            last_iter_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            iter_cnt_q       <= iter_cnt_d;
            prime_cnt_q      <= prime_cnt_d;
            busy_q           <= busy_d;
            update_done_q    <= update_done_d;
            rom_port_fetch_q <= rom_port_fetch_d;
            wr_en_q          <= wr_en_d;
            wr_page_addr_q   <= wr_page_addr_d;
            latch_iter_q     <= latch_iter_d;
            iter_switch_q    <= iter_switch_d;
            last_iter_q      <= last_iter_d;
        end
    end

    assign busy           = busy_q;
    assign update_done    = update_done_q;
    assign rom_port_fetch = rom_port_fetch_q;
    assign wr_en          = wr_en_q;
    assign wr_page_addr   = wr_page_addr_q;
    assign latch_iter     = latch_iter_q;
    assign iter_switch    = iter_switch_q;
    assign last_iter      = last_iter_q;

endmodule
